// File: rtl/demux4_sched.sv
// Scheduled 1-to-4 stream distributor with one registered slot per output channel.
// Routing is by i_sel in fixed mode, or by a round-robin pointer that skips channels unable to accept.
module demux4_sched #(
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_mode,
    input  logic [1:0]    i_sel,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    output logic [3:0]    o_valid,
    input  logic [3:0]    i_ready,
    output logic [DW-1:0] o_data0,
    output logic [DW-1:0] o_data1,
    output logic [DW-1:0] o_data2,
    output logic [DW-1:0] o_data3,
    output logic [1:0]    o_last_ch
);

    // Handshake: a beat moves upstream->slot when i_valid & o_ready, and
    // slot->consumer when o_valid[n] & i_ready[n]; both sampled on the rising edge.

    logic [DW-1:0] r_data [4];
    logic [3:0]    r_valid;
    logic [1:0]    r_last_ch;
    logic [1:0]    r_ptr;

    logic [3:0]    w_can;
    logic          w_rr_hit;
    logic [1:0]    w_rr_tgt;
    logic [1:0]    w_tgt;
    logic          w_xfer;

    assign w_can = ~r_valid | i_ready;

    // Scan from the farthest offset down so the nearest eligible channel after ptr wins.
    always_comb begin
        w_rr_hit = 1'b0;
        w_rr_tgt = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (w_can[r_ptr + 2'(k)]) begin
                w_rr_hit = 1'b1;
                w_rr_tgt = r_ptr + 2'(k);
            end
        end
    end

    assign w_tgt   = i_mode ? w_rr_tgt : i_sel;
    assign o_ready = i_mode ? w_rr_hit : w_can[i_sel];
    assign w_xfer  = i_valid & o_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid   <= 4'b0000;
            r_last_ch <= 2'd0;
            r_ptr     <= 2'd0;
            for (int n = 0; n < 4; n++) begin
                r_data[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (w_xfer && (w_tgt == 2'(n))) begin
                    r_data[n]  <= i_data;
                    r_valid[n] <= 1'b1;
                end else if (i_ready[n]) begin
                    r_valid[n] <= 1'b0;
                end
            end
            if (w_xfer) begin
                r_last_ch <= w_tgt;
                if (i_mode) begin
                    r_ptr <= w_tgt + 2'd1;
                end
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_data0   = r_data[0];
    assign o_data1   = r_data[1];
    assign o_data2   = r_data[2];
    assign o_data3   = r_data[3];
    assign o_last_ch = r_last_ch;

endmodule

// File: tb/tb_demux4_sched.sv
// Self-checking bench for demux4_sched: directed scenarios with literal expectations plus a
// per-cycle comparison against a slot/pointer model of the distributor.
module tb_demux4_sched;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mode = 1'b0;
    logic [1:0]    sel = 2'd0;
    logic          valid = 1'b0;
    logic          ready_o;
    logic [DW-1:0] data = '0;
    logic [3:0]    valid_o;
    logic [3:0]    ready = 4'b0000;
    logic [DW-1:0] d0, d1, d2, d3;
    logic [1:0]    last_ch;
    logic [DW-1:0] dut_data [4];

    int checks = 0;
    int errors = 0;

    demux4_sched #(.DW(DW)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_mode    (mode),
        .i_sel     (sel),
        .i_valid   (valid),
        .o_ready   (ready_o),
        .i_data    (data),
        .o_valid   (valid_o),
        .i_ready   (ready),
        .o_data0   (d0),
        .o_data1   (d1),
        .o_data2   (d2),
        .o_data3   (d3),
        .o_last_ch (last_ch)
    );

    assign dut_data[0] = d0;
    assign dut_data[1] = d1;
    assign dut_data[2] = d2;
    assign dut_data[3] = d3;

    always #5 clk = ~clk;

    // ---------------- model ----------------
    int            m_valid [4];
    int            m_data  [4];
    int            m_last;
    int            m_ptr;

    function automatic bit m_can(int n);
        return (m_valid[n] == 0) || ready[n];
    endfunction

    // Destination of a beat offered now, or -1 if nothing can take it.
    function automatic int m_target();
        if (!mode) return m_can(int'(sel)) ? int'(sel) : -1;
        for (int k = 0; k < 4; k++) begin
            if (m_can((m_ptr + k) % 4)) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                m_valid[n] = 0;
                m_data[n]  = 0;
            end
            m_last = 0;
            m_ptr  = 0;
        end else begin
            int t;
            t = m_target();
            for (int n = 0; n < 4; n++) begin
                if (m_valid[n] != 0 && ready[n]) m_valid[n] = 0;
            end
            if (valid && t >= 0) begin
                m_valid[t] = 1;
                m_data[t]  = int'(data);
                m_last     = t;
                if (mode) m_ptr = (t + 1) % 4;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("cmp_valid%0d", n), int'(valid_o[n]), m_valid[n]);
            chk($sformatf("cmp_data%0d", n), int'(dut_data[n]), m_data[n]);
        end
        chk("cmp_last_ch", int'(last_ch), m_last);
        chk("cmp_ready", int'(ready_o), (m_target() >= 0) ? 1 : 0);
    end

    // ---------------- drivers ----------------
    // Inputs change just after the falling edge, clear of the compare process.
    task automatic set(input bit md, input int s, input bit v, input int d, input int rdy);
        #1;
        mode  = md;
        sel   = 2'(s);
        valid = v;
        data  = DW'(d);
        ready = 4'(rdy);
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic beat(input bit md, input int s, input int d, input int rdy);
        set(md, s, 1'b1, d, rdy);
        tick();
    endtask

    task automatic idle(input int rdy);
        set(mode, 0, 1'b0, 0, rdy);
        tick();
    endtask

    initial begin
        repeat (3) tick();
        #1 rst = 1'b0;
        #1;
        chk("post_reset_ready", int'(ready_o), 1);
        chk("post_reset_valid", int'(valid_o), 0);
        tick();

        // Fixed mode, back-to-back into channel 2.
        beat(1'b0, 2, 'h11, 'hF);
        chk("fix_d2_a", int'(d2), 'h11);
        chk("fix_valid_a", int'(valid_o), 'b0100);
        chk("fix_last_a", int'(last_ch), 2);
        beat(1'b0, 2, 'h22, 'hF);
        chk("fix_d2_b", int'(d2), 'h22);
        chk("fix_valid_b", int'(valid_o), 'b0100);
        idle('hF);
        chk("fix_drained", int'(valid_o), 0);

        // Round-robin fairness A0..A4 -> ch0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            beat(1'b1, 0, 'hA0 + i, 'hF);
            chk($sformatf("rr_last_%0d", i), int'(last_ch), i % 4);
            chk($sformatf("rr_data_%0d", i), int'(dut_data[i % 4]), 'hA0 + i);
        end
        idle('hF);

        // Skip: ptr is 1, ch1 full and stalled.
        beat(1'b0, 1, 'h33, 'b1101);
        beat(1'b1, 0, 'h55, 'b1101);
        chk("skip_last", int'(last_ch), 2);
        chk("skip_d2", int'(d2), 'h55);
        chk("skip_d1_held", int'(d1), 'h33);
        beat(1'b1, 0, 'h66, 'b1101);
        chk("skip_next_last", int'(last_ch), 3);
        chk("skip_next_d3", int'(d3), 'h66);
        idle('hF);

        // Fixed-mode backpressure on ch0.
        beat(1'b0, 0, 'h70, 'hF);
        set(1'b0, 0, 1'b1, 'h71, 'b1110);
        chk("bp_ready_low", int'(ready_o), 0);
        tick();
        chk("bp_d0_held", int'(d0), 'h70);
        set(1'b0, 0, 1'b1, 'h77, 'hF);
        chk("bp_ready_high", int'(ready_o), 1);
        tick();
        chk("bp_d0_new", int'(d0), 'h77);
        chk("bp_valid0", int'(valid_o[0]), 1);
        idle('hF);

        // All blocked in round-robin, then only ch3 frees up.
        for (int i = 0; i < 4; i++) beat(1'b1, 0, 'hB0 + i, 0);
        chk("blk_all_full", int'(valid_o), 'hF);
        set(1'b1, 0, 1'b1, 'hB4, 0);
        chk("blk_ready_low", int'(ready_o), 0);
        tick();
        chk("blk_d0_held", int'(d0), 'hB0);
        beat(1'b1, 0, 'hC0, 'b1000);
        chk("blk_last", int'(last_ch), 3);
        chk("blk_d3", int'(d3), 'hC0);

        // Asynchronous reset in mid-cycle with slots full.
        set(1'b1, 0, 1'b0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", int'(valid_o), 0);
        chk("arst_d3", int'(d3), 0);
        chk("arst_last", int'(last_ch), 0);
        tick();
        #1 rst = 1'b0;
        #1;
        chk("arst_ready", int'(ready_o), 1);
        tick();

        // Mixed traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 60; i++) begin
            set(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux4_sched.md
# demux4_sched

Scheduled 1-to-4 stream distributor: accepts one beat per cycle from a single upstream valid/ready stream and steers it into one of four registered output channels. Destination comes from the sideband select (fixed mode) or from a round-robin scheduler that skips channels unable to accept (round-robin mode). It sits in front of four downstream consumers that share one producer, replacing a bare combinational 1-4 demux where backpressure and fair sharing are needed.

## Interface
Parameters:
- DW, 8, data width of every beat.

Ports:
- i_clk  input  1  single clock; all state on rising edge.
- i_rst  input  1  reset; asynchronous, active-high. One clock; reset is asynchronous and active-high.
- i_mode  input  1  0 = fixed routing by i_sel, 1 = round-robin.
- i_sel  input  2  destination channel in fixed mode; ignored in round-robin mode.
- i_valid  input  1  upstream beat present.
- o_ready  output  1  block accepts the upstream beat this cycle.
- i_data  input  DW  upstream beat.
- o_valid  output  4  per-channel slot full; bit n for channel n.
- i_ready  input  4  per-channel downstream ready.
- o_data0 .. o_data3  output  DW each  per-channel slot contents.
- o_last_ch  output  2  channel that received the most recent accepted beat.

## Operation
- Each channel n has one slot register (o_data{n}, o_valid[n]).
- Slot n drains when o_valid[n] & i_ready[n]; o_valid[n] clears next edge unless refilled on the same edge.
- Slot n can accept when !o_valid[n] | i_ready[n] (empty, or draining this cycle).
- Fixed mode: target = i_sel; o_ready = can_accept[i_sel].
- Round-robin mode: 2-bit pointer ptr; target = first n in order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with can_accept[n]; o_ready = OR of can_accept.
- Transfer when i_valid & o_ready: target slot loads i_data, o_valid[target] set, o_last_ch <= target.
- In round-robin mode, ptr <= target+1 (mod 4, natural 2-bit wrap 3 -> 0) only on a transfer; no transfer leaves ptr unchanged.
- Fixed-mode transfers leave ptr unchanged.
- i_mode is sampled every cycle; switching takes effect the same cycle and does not clear slots or ptr.
- Same-cycle drain and refill of one slot: new data loads, o_valid stays 1, no bubble.
- Slots are independent: any number may drain in the same cycle a different slot fills.
- o_ready is combinational from i_mode, i_sel, o_valid, i_ready; it never depends on i_valid.
- Reset mid-operation: all slots are discarded immediately (asynchronous); in-flight beats are lost, and upstream must resend.

## Timing
- Reset values: o_valid = 4'b0000, o_data0..3 = 0, o_last_ch = 0, ptr = 0. o_ready after reset = 1 (all slots empty).
- Latency: beat accepted on edge k appears on o_data{target} with o_valid set after edge k; visible in cycle k+1.
- Throughput: one beat per cycle sustained while any eligible target can accept.
- A slot's data holds stable while o_valid[n]=1 and i_ready[n]=0.
- No combinational path from i_valid or i_data to any output.

## Test plan
- Reset: assert i_rst mid-cycle with slots full -> o_valid = 0000, o_data* = 0, o_last_ch = 0 immediately. After release, o_ready = 1.
- Fixed mode: i_mode=0, i_sel=2, i_ready=1111, send 0x11, 0x22 back-to-back -> o_data2 = 0x11 then 0x22 in consecutive cycles, o_valid = 0100 both cycles, o_last_ch = 2.
- Round-robin fairness: i_mode=1, i_ready=1111, send 0xA0..0xA4 consecutively -> beats land on ch0, 1, 2, 3, 0; ptr wraps 3 -> 0.
- Round-robin skip: ch1 slot full with i_ready[1]=0, ptr=1, send 0x55 -> lands on ch2, o_last_ch = 2, ch1 data unchanged. Next beat goes to ch3.
- Fixed-mode backpressure: i_sel=0, o_valid[0]=1, i_ready[0]=0 -> o_ready = 0, no transfer. Raise i_ready[0] with i_valid=1 and data 0x77 -> o_ready = 1, o_data0 = 0x77 next cycle, o_valid[0] stays 1.
- All blocked in round-robin: o_valid=1111, i_ready=0000 -> o_ready = 0, ptr unchanged. Raise only i_ready[3] -> next beat targets ch3.
